// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - control/data bundle between the EX-stage control path and the mult/div unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit holding the result in HI/LO
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mult_div_unit_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               zero_div_q, zero_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign is_signed = ~bus.op[0];
  assign rs_neg    = is_signed & bus.rs_data[WIDTH-1];
  assign rt_neg    = is_signed & bus.rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    zero_div_d = zero_div_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          state_d    = CALC;
          cnt_d      = '0;
          is_div_d   = bus.op[1];
          neg_lo_d   = rs_neg ^ rt_neg;
          neg_hi_d   = rs_neg;
          zero_div_d = bus.op[1] & (bus.rt_data == {WIDTH{1'b0}});
          dbz_d      = 1'b0;
          if (bus.op[1]) begin
            opnd_d = rt_mag;
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
          end else begin
            opnd_d = rs_mag;
            acc_d  = {{WIDTH{1'b0}}, rt_mag};
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = zero_div_q;
        // A zero divisor leaves |rs| in the remainder, so only LO needs forcing
        if (is_div_q) begin
          lo_d = zero_div_q ? {WIDTH{1'b1}} : (neg_lo_q ? -quo : quo);
          hi_d = neg_hi_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      zero_div_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      zero_div_q <= zero_div_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
